calc_keypad_ctrl: RTL and testbench

// Parametrised keypad/entry controller for the calculator. Hit-tests mouse position against an
// on-screen 4x4 key grid, turns each click into one keypress, assembles decimal operand A,

---
 rtl/calc_pkg.sv | 79 +++++++
 rtl/calc_key_decoder.sv | 66 ++++++
 rtl/calc_keypad_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_calc_keypad_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, op codes, FSM encoding and key helpers for the calculator keypad
//
// Purpose : Common definitions imported by calc_key_decoder and calc_keypad_ctrl.
//           Key codes are grid positions (col + 4*row), so the hit-test result is the key code.
// Ports   : none (package)

package calc_pkg;

   localparam int GRID_COLS = 4;
   localparam int GRID_ROWS = 4;

   // Layout, row-major from top-left: 7 8 9 + / 4 5 6 - / 1 2 3 * / C 0 = /
   localparam logic [4:0] KEY_7    = 5'd0;
   localparam logic [4:0] KEY_8    = 5'd1;
   localparam logic [4:0] KEY_9    = 5'd2;
   localparam logic [4:0] KEY_ADD  = 5'd3;
   localparam logic [4:0] KEY_4    = 5'd4;
   localparam logic [4:0] KEY_5    = 5'd5;
   localparam logic [4:0] KEY_6    = 5'd6;
   localparam logic [4:0] KEY_SUB  = 5'd7;
   localparam logic [4:0] KEY_1    = 5'd8;
   localparam logic [4:0] KEY_2    = 5'd9;
   localparam logic [4:0] KEY_3    = 5'd10;
   localparam logic [4:0] KEY_MUL  = 5'd11;
   localparam logic [4:0] KEY_CLR  = 5'd12;
   localparam logic [4:0] KEY_0    = 5'd13;
   localparam logic [4:0] KEY_EQ   = 5'd14;
   localparam logic [4:0] KEY_DIV  = 5'd15;
   localparam logic [4:0] KEY_NONE = 5'h1F;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   typedef enum logic [1:0] {
      ST_ENTER_A = 2'd0,
      ST_ENTER_B = 2'd1,
      ST_WAIT    = 2'd2,
      ST_SHOW    = 2'd3
   } calc_state_t;

   function automatic logic key_is_digit(input logic [4:0] k);
      case (k)
         KEY_0, KEY_1, KEY_2, KEY_3, KEY_4,
         KEY_5, KEY_6, KEY_7, KEY_8, KEY_9: return 1'b1;
         default:                           return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] key_digit(input logic [4:0] k);
      case (k)
         KEY_1:   return 4'd1;
         KEY_2:   return 4'd2;
         KEY_3:   return 4'd3;
         KEY_4:   return 4'd4;
         KEY_5:   return 4'd5;
         KEY_6:   return 4'd6;
         KEY_7:   return 4'd7;
         KEY_8:   return 4'd8;
         KEY_9:   return 4'd9;
         default: return 4'd0;
      endcase
   endfunction

   function automatic logic key_is_op(input logic [4:0] k);
      return (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL) || (k == KEY_DIV);
   endfunction

   function automatic logic [1:0] key_op(input logic [4:0] k);
      case (k)
         KEY_SUB: return OP_SUB;
         KEY_MUL: return OP_MUL;
         KEY_DIV: return OP_DIV;
         default: return OP_ADD;
      endcase
   endfunction

endpackage

// File: rtl/calc_key_decoder.sv
// rtl/calc_key_decoder.sv - registered hit-test of the cursor against the 4x4 key grid
//
// Purpose : Maps cursor position to the key under it, one cycle after the position changes.
//           Column/row are found with compare chains against the key boundaries (no division).
// Ports   : clk, reset (async, active-high)
//           mouse_x, mouse_y [9:0] - cursor position in pixels
//           hover_key [4:0]        - key code under cursor, KEY_NONE when outside the grid

module calc_key_decoder
   import calc_pkg::*;
#(
   parameter int GRID_X0 = 400,
   parameter int GRID_Y0 = 120,
   parameter int KEY_W   = 40,
   parameter int KEY_H   = 40
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] mouse_x,
   input  logic [9:0] mouse_y,
   output logic [4:0] hover_key
);

   logic [10:0] xe;
   logic [10:0] ye;
   logic [1:0]  col;
   logic [1:0]  row;
   logic        col_hit;
   logic        row_hit;
   logic [4:0]  hover_d;

   assign xe = {1'b0, mouse_x};
   assign ye = {1'b0, mouse_y};

   // Left/top edges are inclusive, right/bottom exclusive.
   always_comb begin
      col     = 2'd0;
      col_hit = 1'b0;
      for (int c = 0; c < GRID_COLS; c++) begin
         if (xe >= 11'(GRID_X0 + c * KEY_W) && xe < 11'(GRID_X0 + (c + 1) * KEY_W)) begin
            col     = 2'(c);
            col_hit = 1'b1;
         end
      end
   end

   always_comb begin
      row     = 2'd0;
      row_hit = 1'b0;
      for (int r = 0; r < GRID_ROWS; r++) begin
         if (ye >= 11'(GRID_Y0 + r * KEY_H) && ye < 11'(GRID_Y0 + (r + 1) * KEY_H)) begin
            row     = 2'(r);
            row_hit = 1'b1;
         end
      end
   end

   // Key code is col + 4*row, i.e. {row, col}.
   assign hover_d = (col_hit && row_hit) ? {1'b0, row, col} : KEY_NONE;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) hover_key <= KEY_NONE;
      else       hover_key <= hover_d;
   end

endmodule

// File: rtl/calc_keypad_ctrl.sv
// rtl/calc_keypad_ctrl.sv - calculator keypad entry controller with ALU start/done handshake
//
// Purpose : Turns mouse clicks on the on-screen key grid into keypresses, assembles
//           operand A, operator and operand B, and drives the ALU request/response.
// Ports   : clk, reset (async, active-high)
//           mouse_x, mouse_y, mouse_click        - from mouse controller
//           alu_result, alu_err, alu_done        - ALU response (done is a 1-cycle pulse)
//           alu_start                            - 1-cycle ALU request
//           operand_a, operand_b, op_code, op_valid, result, result_valid, error
//                                                - entry/result state for the pixel generator
//           hover_key                            - key under cursor (KEY_NONE = none)
//           state                                - FSM state for display/debug

module calc_keypad_ctrl
   import calc_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int MAX_DIGITS = 4,
   parameter int GRID_X0    = 400,
   parameter int GRID_Y0    = 120,
   parameter int KEY_W      = 40,
   parameter int KEY_H      = 40
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [9:0]        mouse_x,
   input  logic [9:0]        mouse_y,
   input  logic              mouse_click,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_err,
   input  logic              alu_done,
   output logic              alu_start,
   output logic [DATA_W-1:0] operand_a,
   output logic [DATA_W-1:0] operand_b,
   output logic [1:0]        op_code,
   output logic              op_valid,
   output logic [4:0]        hover_key,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   output logic              error,
   output logic [1:0]        state
);

   localparam int CW = $clog2(MAX_DIGITS + 1);

   calc_state_t       state_q, state_d;
   logic [DATA_W-1:0] a_d, b_d, res_d;
   logic [1:0]        op_d;
   logic              opv_d, rv_d, err_d, start_d;
   logic [CW-1:0]     cnt_a, cnt_b, cnt_a_d, cnt_b_d;
   logic              b_any, b_any_d;   // any digit (including 0) typed into B
   logic              click_q, click_q2;
   logic              press;
   logic              is_dig, is_op;
   logic [3:0]        dig;

   function automatic logic [DATA_W-1:0] acc_push(input logic [DATA_W-1:0] acc,
                                                  input logic [3:0] d);
      return (acc << 3) + (acc << 1) + DATA_W'(d);
   endfunction

   calc_key_decoder #(
      .GRID_X0 (GRID_X0),
      .GRID_Y0 (GRID_Y0),
      .KEY_W   (KEY_W),
      .KEY_H   (KEY_H)
   ) u_decoder (
      .clk       (clk),
      .reset     (reset),
      .mouse_x   (mouse_x),
      .mouse_y   (mouse_y),
      .hover_key (hover_key)
   );

   // One press per rising edge of the registered button level, using the key hovered then.
   assign press  = click_q && !click_q2 && (hover_key != KEY_NONE);
   assign is_dig = key_is_digit(hover_key);
   assign is_op  = key_is_op(hover_key);
   assign dig    = key_digit(hover_key);
   assign state  = state_q;

   always_comb begin
      state_d = state_q;
      a_d     = operand_a;
      b_d     = operand_b;
      op_d    = op_code;
      opv_d   = op_valid;
      res_d   = result;
      rv_d    = result_valid;
      err_d   = error;
      cnt_a_d = cnt_a;
      cnt_b_d = cnt_b;
      b_any_d = b_any;
      start_d = 1'b0;

      // Clear has priority over everything, including a coincident alu_done.
      if (press && hover_key == KEY_CLR) begin
         a_d     = '0;
         b_d     = '0;
         op_d    = OP_ADD;
         opv_d   = 1'b0;
         rv_d    = 1'b0;
         err_d   = 1'b0;
         cnt_a_d = '0;
         cnt_b_d = '0;
         b_any_d = 1'b0;
         state_d = ST_ENTER_A;
      end else if (state_q == ST_WAIT) begin
         if (alu_done) begin
            res_d   = alu_result;
            err_d   = alu_err;
            rv_d    = 1'b1;
            state_d = ST_SHOW;
         end
      end else if (press) begin
         case (state_q)
            ST_ENTER_A: begin
               if (is_dig) begin
                  // A leading zero leaves the value at 0 and is not counted.
                  if (!(cnt_a == '0 && dig == 4'd0) && cnt_a < CW'(MAX_DIGITS)) begin
                     a_d     = acc_push(operand_a, dig);
                     cnt_a_d = cnt_a + CW'(1);
                  end
               end else if (is_op) begin
                  op_d    = key_op(hover_key);
                  opv_d   = 1'b1;
                  state_d = ST_ENTER_B;
               end
            end
            ST_ENTER_B: begin
               if (is_dig) begin
                  b_any_d = 1'b1;
                  if (!(cnt_b == '0 && dig == 4'd0) && cnt_b < CW'(MAX_DIGITS)) begin
                     b_d     = acc_push(operand_b, dig);
                     cnt_b_d = cnt_b + CW'(1);
                  end
               end else if (is_op) begin
                  if (!b_any) op_d = key_op(hover_key);
               end else if (hover_key == KEY_EQ && b_any) begin
                  start_d = 1'b1;
                  state_d = ST_WAIT;
               end
            end
            ST_SHOW: begin
               if (is_dig) begin
                  a_d     = DATA_W'(dig);
                  cnt_a_d = (dig != 4'd0) ? CW'(1) : '0;
                  b_d     = '0;
                  cnt_b_d = '0;
                  b_any_d = 1'b0;
                  op_d    = OP_ADD;
                  opv_d   = 1'b0;
                  res_d   = '0;
                  rv_d    = 1'b0;
                  err_d   = 1'b0;
                  state_d = ST_ENTER_A;
               end else if (is_op) begin
                  // Chain: previous result becomes A (0 if it was an error).
                  a_d     = error ? '0 : result;
                  b_d     = '0;
                  cnt_b_d = '0;
                  b_any_d = 1'b0;
                  op_d    = key_op(hover_key);
                  opv_d   = 1'b1;
                  rv_d    = 1'b0;
                  err_d   = 1'b0;
                  state_d = ST_ENTER_B;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_ENTER_A;
         operand_a    <= '0;
         operand_b    <= '0;
         op_code      <= OP_ADD;
         op_valid     <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         error        <= 1'b0;
         alu_start    <= 1'b0;
         cnt_a        <= '0;
         cnt_b        <= '0;
         b_any        <= 1'b0;
         click_q      <= 1'b0;
         click_q2     <= 1'b0;
      end else begin
         state_q      <= state_d;
         operand_a    <= a_d;
         operand_b    <= b_d;
         op_code      <= op_d;
         op_valid     <= opv_d;
         result       <= res_d;
         result_valid <= rv_d;
         error        <= err_d;
         alu_start    <= start_d;
         cnt_a        <= cnt_a_d;
         cnt_b        <= cnt_b_d;
         b_any        <= b_any_d;
         click_q      <= mouse_click;
         click_q2     <= click_q;
      end
   end

endmodule

// File: tb/tb_calc_keypad_ctrl.sv
// tb/tb_calc_keypad_ctrl.sv - self-checking bench for calc_keypad_ctrl

module tb_calc_keypad_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  mouse_x, mouse_y;
   logic        mouse_click;
   logic [15:0] alu_result;
   logic        alu_err, alu_done;
   logic        alu_start;
   logic [15:0] operand_a, operand_b, result;
   logic [1:0]  op_code, state;
   logic        op_valid, result_valid, error;
   logic [4:0]  hover_key;

   calc_keypad_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .mouse_x      (mouse_x),
      .mouse_y      (mouse_y),
      .mouse_click  (mouse_click),
      .alu_result   (alu_result),
      .alu_err      (alu_err),
      .alu_done     (alu_done),
      .alu_start    (alu_start),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .op_code      (op_code),
      .op_valid     (op_valid),
      .hover_key    (hover_key),
      .result       (result),
      .result_valid (result_valid),
      .error        (error),
      .state        (state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   int exp_starts = 0;

   always @(negedge clk) if (alu_start === 1'b1) start_cnt++;

   // Reference model: calculator entry state kept as plain integers.
   int m_state, m_a, m_b, m_op, m_opv, m_res, m_rv, m_err, m_ca, m_cb, m_bany;
   int dig_of [16] = '{7, 8, 9, -1, 4, 5, 6, -1, 1, 2, 3, -1, -1, 0, -1, -1};
   int op_of  [16] = '{-1, -1, -1, 0, -1, -1, -1, 1, -1, -1, -1, 2, -1, -1, -1, 3};

   typedef struct {
      int x;
      int y;
      int exp_key;
   } hit_vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_opv = 0;
      m_res = 0; m_rv = 0; m_err = 0; m_ca = 0; m_cb = 0; m_bany = 0;
   endtask

   task automatic model_press(input int k);
      int d, o;
      if (k < 0 || k > 15) return;
      d = dig_of[k];
      o = op_of[k];
      if (k == 12) begin
         m_a = 0; m_b = 0; m_op = 0; m_opv = 0; m_rv = 0; m_err = 0;
         m_ca = 0; m_cb = 0; m_bany = 0; m_state = 0;
         return;
      end
      case (m_state)
         0: if (d >= 0) begin
               if (!(m_ca == 0 && d == 0) && m_ca < 4) begin m_a = (m_a * 10 + d) % 65536; m_ca++; end
            end else if (o >= 0) begin
               m_op = o; m_opv = 1; m_state = 1;
            end
         1: if (d >= 0) begin
               m_bany = 1;
               if (!(m_cb == 0 && d == 0) && m_cb < 4) begin m_b = (m_b * 10 + d) % 65536; m_cb++; end
            end else if (o >= 0) begin
               if (m_bany == 0) m_op = o;
            end else if (k == 14 && m_bany != 0) begin
               exp_starts++; m_state = 2;
            end
         3: if (d >= 0) begin
               m_a = d; m_ca = (d != 0) ? 1 : 0; m_b = 0; m_cb = 0; m_bany = 0;
               m_op = 0; m_opv = 0; m_res = 0; m_rv = 0; m_err = 0; m_state = 0;
            end else if (o >= 0) begin
               m_a = (m_err != 0) ? 0 : m_res; m_b = 0; m_cb = 0; m_bany = 0;
               m_op = o; m_opv = 1; m_rv = 0; m_err = 0; m_state = 1;
            end
         default: ;
      endcase
   endtask

   task automatic model_check(input string tag);
      check({tag, ".state"},  state,        m_state);
      check({tag, ".a"},      operand_a,    m_a);
      check({tag, ".b"},      operand_b,    m_b);
      check({tag, ".op"},     op_code,      m_op);
      check({tag, ".opv"},    op_valid,     m_opv);
      check({tag, ".res"},    result,       m_res);
      check({tag, ".rv"},     result_valid, m_rv);
      check({tag, ".err"},    error,        m_err);
      check({tag, ".starts"}, start_cnt,    exp_starts);
   endtask

   task automatic place_cursor(input int k);
      if (k < 0 || k > 15) begin
         mouse_x = 10'($urandom_range(0, 399));
         mouse_y = 10'($urandom_range(0, 119));
      end else begin
         mouse_x = 10'(400 + (k % 4) * 40 + $urandom_range(0, 39));
         mouse_y = 10'(120 + (k / 4) * 40 + $urandom_range(0, 39));
      end
   endtask

   // k = 0..15 key code, 31 = click outside the grid
   task automatic press(input int k, input int hold);
      @(negedge clk);
      place_cursor(k);
      @(negedge clk);
      mouse_click = 1'b1;
      repeat (hold) @(negedge clk);
      mouse_click = 1'b0;
      repeat (2) @(negedge clk);
      model_press(k);
      check("hover", hover_key, (k < 0 || k > 15) ? 31 : k);
   endtask

   task automatic deliver_done(input int res, input int err, input int delay);
      repeat (delay) @(negedge clk);
      alu_result = 16'(res);
      alu_err    = (err != 0);
      alu_done   = 1'b1;
      @(negedge clk);
      alu_done   = 1'b0;
      alu_err    = 1'b0;
      @(negedge clk);
      if (m_state == 2) begin
         m_res = res % 65536; m_err = err; m_rv = 1; m_state = 3;
      end
   endtask

   hit_vec_t hv [10];

   initial begin
      int s0, prev_key;
      reset = 1'b1; mouse_x = '0; mouse_y = '0; mouse_click = 1'b0;
      alu_result = '0; alu_err = 1'b0; alu_done = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      check("rst.hover", hover_key, 31);
      check("rst.start", alu_start, 0);
      model_check("rst");

      hv[0] = '{405, 125, 0};   hv[1] = '{559, 279, 15};  hv[2] = '{560, 279, 31};
      hv[3] = '{400, 120, 0};   hv[4] = '{399, 120, 31};  hv[5] = '{400, 119, 31};
      hv[6] = '{440, 160, 5};   hv[7] = '{480, 200, 10};  hv[8] = '{559, 280, 31};
      hv[9] = '{439, 279, 12};
      prev_key = 31;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         mouse_x = 10'(hv[i].x);
         mouse_y = 10'(hv[i].y);
         #1 check($sformatf("hit%0d.lat", i), hover_key, prev_key);
         @(negedge clk);
         check($sformatf("hit%0d", i), hover_key, hv[i].exp_key);
         prev_key = hv[i].exp_key;
      end

      // 12 + 3 =
      s0 = start_cnt;
      press(8, 1); press(9, 2); press(3, 1); press(10, 3); press(14, 1);
      check("seq1.a", operand_a, 12);
      check("seq1.op", op_code, 0);
      check("seq1.b", operand_b, 3);
      check("seq1.start", start_cnt - s0, 1);
      check("seq1.state", state, 2);
      deliver_done(15, 0, 5);
      check("seq1.res", result, 15);
      check("seq1.rv", result_valid, 1);
      check("seq1.show", state, 3);
      model_check("seq1");

      // chain * 2 = with ALU error
      s0 = start_cnt;
      press(11, 1); press(9, 1); press(14, 1);
      check("seq2.a", operand_a, 15);
      check("seq2.op", op_code, 2);
      check("seq2.start", start_cnt - s0, 1);
      repeat (4) @(negedge clk);
      check("seq2.nostart", start_cnt - s0, 1);
      deliver_done(30, 1, 2);
      check("seq2.err", error, 1);
      model_check("seq2");

      // held click is one press; fifth digit ignored
      press(12, 1);
      press(5, 50);
      check("hold.a", operand_a, 5);
      press(12, 1);
      for (int i = 0; i < 5; i++) press(2, 1);
      check("max.a", operand_a, 9999);
      model_check("max");

      // C coincident with alu_done in WAIT
      press(12, 1); press(4, 1); press(3, 1); press(9, 1); press(14, 1);
      check("cdone.wait", state, 2);
      @(negedge clk);
      place_cursor(12);
      @(negedge clk);
      mouse_click = 1'b1;
      @(negedge clk);
      mouse_click = 1'b0;
      alu_result = 16'd77;
      alu_done = 1'b1;
      @(negedge clk);
      alu_done = 1'b0;
      @(negedge clk);
      model_press(12);
      check("cdone.state", state, 0);
      check("cdone.rv", result_valid, 0);
      model_check("cdone");

      // reset in WAIT, then a stray alu_done
      press(0, 1); press(7, 1); press(8, 1); press(14, 1);
      check("rwait.wait", state, 2);
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      deliver_done(123, 1, 1);
      check("rwait.state", state, 0);
      check("rwait.rv", result_valid, 0);
      model_check("rwait");

      // asynchronous reset mid-entry
      press(10, 1); press(4, 1);
      check("ar.pre", operand_a, 34);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("ar.a", operand_a, 0);
      check("ar.hover", hover_key, 31);
      check("ar.state", state, 0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();

      for (int i = 0; i < 300; i++) begin
         if (m_state == 2 && $urandom_range(0, 2) != 0) begin
            deliver_done($urandom_range(0, 65535), ($urandom_range(0, 7) == 0) ? 1 : 0,
                         $urandom_range(1, 5));
         end else if ($urandom_range(0, 9) == 0) begin
            press(31, $urandom_range(1, 4));
         end else begin
            press($urandom_range(0, 15), $urandom_range(1, 4));
         end
         model_check($sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
